// File: rtl/register_arbiter.sv
// Two-requester arbiter in front of a shared Hack register: round-robin grants,
// optional ownership lock for read-modify-write, and a watchdog on held locks.
module register_arbiter #(
   parameter int WIDTH    = 16,
   parameter int LOCK_MAX = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic             req1,
   input  logic             we0,
   input  logic             we1,
   input  logic             lock0,
   input  logic             lock1,
   input  logic [WIDTH-1:0] wdata0,
   input  logic [WIDTH-1:0] wdata1,
   output logic             ack0,
   output logic             ack1,
   output logic [WIDTH-1:0] rdata,
   output logic             reg_load,
   output logic [WIDTH-1:0] reg_in,
   input  logic [WIDTH-1:0] reg_out,
   output logic [1:0]       owner,
   output logic             lock_err
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN0 = 2'b01,
      OWN1 = 2'b10
   } state_t;

   localparam logic [7:0] WD_LIMIT = 8'(LOCK_MAX - 1);

   state_t           state, state_n;
   logic             last, last_n;
   logic [7:0]       wd_count, wd_n;
   logic             ack0_n, ack1_n, load_n, err_n;
   logic [WIDTH-1:0] in_n;
   logic             elig0, elig1, grant0, grant1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         last     <= 1'b1;
         wd_count <= 8'd0;
         ack0     <= 1'b0;
         ack1     <= 1'b0;
         reg_load <= 1'b0;
         reg_in   <= '0;
         lock_err <= 1'b0;
      end else begin
         state    <= state_n;
         last     <= last_n;
         wd_count <= wd_n;
         ack0     <= ack0_n;
         ack1     <= ack1_n;
         reg_load <= load_n;
         reg_in   <= in_n;
         lock_err <= err_n;
      end
   end

   // A requester whose ack is still high is ignored so a slow req drop cannot double-grant.
   always_comb begin
      state_n = state;
      last_n  = last;
      wd_n    = wd_count;
      ack0_n  = 1'b0;
      ack1_n  = 1'b0;
      load_n  = 1'b0;
      in_n    = reg_in;
      err_n   = 1'b0;

      elig0  = req0 && !ack0 && (state != OWN1);
      elig1  = req1 && !ack1 && (state != OWN0);
      grant0 = elig0 && (!elig1 || last);
      grant1 = elig1 && (!elig0 || !last);

      if (grant0) begin
         ack0_n  = 1'b1;
         last_n  = 1'b0;
         wd_n    = 8'd0;
         state_n = lock0 ? OWN0 : IDLE;
         if (we0) begin
            load_n = 1'b1;
            in_n   = wdata0;
         end
      end else if (grant1) begin
         ack1_n  = 1'b1;
         last_n  = 1'b1;
         wd_n    = 8'd0;
         state_n = lock1 ? OWN1 : IDLE;
         if (we1) begin
            load_n = 1'b1;
            in_n   = wdata1;
         end
      end else if (state == OWN0) begin
         if (!req0 && !lock0) begin
            state_n = IDLE;
         end else if (wd_count == WD_LIMIT) begin
            state_n = IDLE;
            err_n   = 1'b1;
            last_n  = 1'b0;
            wd_n    = 8'd0;
         end else begin
            wd_n = wd_count + 8'd1;
         end
      end else if (state == OWN1) begin
         if (!req1 && !lock1) begin
            state_n = IDLE;
         end else if (wd_count == WD_LIMIT) begin
            state_n = IDLE;
            err_n   = 1'b1;
            last_n  = 1'b1;
            wd_n    = 8'd0;
         end else begin
            wd_n = wd_count + 8'd1;
         end
      end
   end

   assign owner = state;
   assign rdata = reg_out;

endmodule

// File: tb/tb_register_arbiter.sv
// Self-checking bench for register_arbiter: directed scenarios plus randomized
// traffic compared against a behavioural model of the arbitration rules.
module tb_register_arbiter;

   localparam int WIDTH    = 16;
   localparam int LOCK_MAX = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [1:0]       req = 2'b00;
   logic [1:0]       we = 2'b00;
   logic [1:0]       lock = 2'b00;
   logic [WIDTH-1:0] wdata [2];
   logic             ack0, ack1, reg_load, lock_err;
   logic [WIDTH-1:0] rdata, reg_in;
   logic [WIDTH-1:0] reg_out = '0;
   logic [1:0]       owner;

   int total = 0;
   int bad   = 0;

   // Behavioural model state: owner index (-1 none), last winner, lock age.
   int               m_owner;
   int               m_last;
   int               m_wd;
   logic [1:0]       m_ack;
   logic             m_load;
   logic             m_err;
   logic [WIDTH-1:0] m_in;
   logic [WIDTH-1:0] m_reg = '0;

   register_arbiter #(.WIDTH(WIDTH), .LOCK_MAX(LOCK_MAX)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req[0]), .req1(req[1]),
      .we0(we[0]), .we1(we[1]),
      .lock0(lock[0]), .lock1(lock[1]),
      .wdata0(wdata[0]), .wdata1(wdata[1]),
      .ack0(ack0), .ack1(ack1), .rdata(rdata),
      .reg_load(reg_load), .reg_in(reg_in), .reg_out(reg_out),
      .owner(owner), .lock_err(lock_err)
   );

   always #5 clk = ~clk;

   // The shared Hack register: no reset, captures on load.
   always @(posedge clk) begin
      if (reg_load) reg_out <= reg_in;
   end

   always @(posedge clk or negedge rst_n) begin
      int elig [2];
      int g;
      if (!rst_n) begin
         m_owner = -1; m_last = 1; m_wd = 0;
         m_ack = 2'b00; m_load = 1'b0; m_err = 1'b0; m_in = '0;
      end else begin
         if (m_load) m_reg = m_in;
         for (int n = 0; n < 2; n++)
            elig[n] = (req[n] && !m_ack[n] && (m_owner < 0 || m_owner == n)) ? 1 : 0;
         g = -1;
         if (elig[0] == 1 && elig[1] == 1) g = 1 - m_last;
         else if (elig[0] == 1) g = 0;
         else if (elig[1] == 1) g = 1;
         m_ack = 2'b00; m_load = 1'b0; m_err = 1'b0;
         if (g >= 0) begin
            m_ack[g] = 1'b1;
            if (we[g]) begin
               m_load = 1'b1;
               m_in   = wdata[g];
            end
            m_last  = g;
            m_owner = lock[g] ? g : -1;
            m_wd    = 0;
         end else if (m_owner >= 0) begin
            if (!req[m_owner] && !lock[m_owner]) begin
               m_owner = -1;
            end else if (m_wd + 1 >= LOCK_MAX) begin
               m_last  = m_owner;
               m_owner = -1;
               m_err   = 1'b1;
               m_wd    = 0;
            end else begin
               m_wd = m_wd + 1;
            end
         end
      end
   end

   task automatic test_reset();
      rst_n = 1'b0; req = 2'b11; we = 2'b00; lock = 2'b00;
      wdata[0] = '0; wdata[1] = '0;
      repeat (3) @(negedge clk);
      total++; if ({ack1, ack0, reg_load, lock_err} !== 4'b0000) begin bad++; $display("[TB] FAIL reset_flags got=%b exp=0000", {ack1, ack0, reg_load, lock_err}); end
      total++; if (owner !== 2'b00) begin bad++; $display("[TB] FAIL reset_owner got=%b exp=00", owner); end
      total++; if (reg_in !== 16'h0000) begin bad++; $display("[TB] FAIL reset_reg_in got=%h exp=0000", reg_in); end
      rst_n = 1'b1;
      @(negedge clk);
      total++; if ({ack1, ack0} !== 2'b01) begin bad++; $display("[TB] FAIL reset_first_grant got=%b exp=01", {ack1, ack0}); end
      req[0] = 1'b0;
      @(negedge clk);
      total++; if ({ack1, ack0} !== 2'b10) begin bad++; $display("[TB] FAIL reset_second_grant got=%b exp=10", {ack1, ack0}); end
      req[1] = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_write_read();
      req[0] = 1'b1; we[0] = 1'b1; wdata[0] = 16'h8285; lock[0] = 1'b0;
      @(negedge clk);
      total++; if ({ack0, reg_load} !== 2'b11) begin bad++; $display("[TB] FAIL wr_ack_load got=%b exp=11", {ack0, reg_load}); end
      total++; if (reg_in !== 16'h8285) begin bad++; $display("[TB] FAIL wr_reg_in got=%h exp=8285", reg_in); end
      req[0] = 1'b0; we[0] = 1'b0;
      req[1] = 1'b1; we[1] = 1'b0;
      @(negedge clk);
      total++; if ({ack1, ack0, reg_load} !== 3'b100) begin bad++; $display("[TB] FAIL rd_ack got=%b exp=100", {ack1, ack0, reg_load}); end
      total++; if (rdata !== 16'h8285) begin bad++; $display("[TB] FAIL rd_data got=%h exp=8285", rdata); end
      req[1] = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_contention();
      we = 2'b11; wdata[0] = 16'h3039; wdata[1] = 16'h0001; req = 2'b11;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         total++; if ({ack1, ack0, reg_load} !== ((i % 2 == 0) ? 3'b011 : 3'b101)) begin bad++; $display("[TB] FAIL contention_ack[%0d] got=%b exp=%b", i, {ack1, ack0, reg_load}, (i % 2 == 0) ? 3'b011 : 3'b101); end
         total++; if (reg_in !== ((i % 2 == 0) ? 16'h3039 : 16'h0001)) begin bad++; $display("[TB] FAIL contention_data[%0d] got=%h exp=%h", i, reg_in, (i % 2 == 0) ? 16'h3039 : 16'h0001); end
         req[0] = !ack0;
         req[1] = !ack1;
      end
      req = 2'b00; we = 2'b00;
      @(negedge clk);
   endtask

   task automatic test_lock_rmw();
      req[0] = 1'b1; lock[0] = 1'b1; we[0] = 1'b0;
      @(negedge clk);
      total++; if ({ack0, owner} !== 3'b101) begin bad++; $display("[TB] FAIL rmw_lock got=%b exp=101", {ack0, owner}); end
      req[0] = 1'b0; req[1] = 1'b1; we[1] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         total++; if ({ack1, owner} !== 3'b001) begin bad++; $display("[TB] FAIL rmw_blocked[%0d] got=%b exp=001", i, {ack1, owner}); end
      end
      req[0] = 1'b1; we[0] = 1'b1; wdata[0] = 16'h7FFF; lock[0] = 1'b0;
      @(negedge clk);
      total++; if ({ack0, reg_load, owner} !== 4'b1100) begin bad++; $display("[TB] FAIL rmw_write got=%b exp=1100", {ack0, reg_load, owner}); end
      total++; if (reg_in !== 16'h7FFF) begin bad++; $display("[TB] FAIL rmw_data got=%h exp=7fff", reg_in); end
      req[0] = 1'b0; we[0] = 1'b0;
      @(negedge clk);
      total++; if ({ack1, rdata} !== {1'b1, 16'h7FFF}) begin bad++; $display("[TB] FAIL rmw_release got=%b/%h exp=1/7fff", ack1, rdata); end
      req[1] = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_watchdog();
      req[0] = 1'b1; lock[0] = 1'b1; we[0] = 1'b0;
      @(negedge clk);
      total++; if ({ack0, owner} !== 3'b101) begin bad++; $display("[TB] FAIL wd_grant got=%b exp=101", {ack0, owner}); end
      req[0] = 1'b0; req[1] = 1'b1; we[1] = 1'b0;
      for (int i = 1; i < LOCK_MAX; i++) begin
         @(negedge clk);
         total++; if ({lock_err, ack1, owner} !== 4'b0001) begin bad++; $display("[TB] FAIL wd_hold[%0d] got=%b exp=0001", i, {lock_err, ack1, owner}); end
      end
      @(negedge clk);
      total++; if ({lock_err, ack1, owner} !== 4'b1000) begin bad++; $display("[TB] FAIL wd_expire got=%b exp=1000", {lock_err, ack1, owner}); end
      lock[0] = 1'b0;
      @(negedge clk);
      total++; if ({lock_err, ack1} !== 2'b01) begin bad++; $display("[TB] FAIL wd_next_grant got=%b exp=01", {lock_err, ack1}); end
      req[1] = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_write();
      req[0] = 1'b1; we[0] = 1'b1; wdata[0] = 16'h1234; lock[0] = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      total++; if ({ack0, reg_load} !== 2'b00) begin bad++; $display("[TB] FAIL midreset_clear got=%b exp=00", {ack0, reg_load}); end
      @(negedge clk);
      total++; if (rdata !== 16'h7FFF) begin bad++; $display("[TB] FAIL midreset_keep got=%h exp=7fff", rdata); end
      req[0] = 1'b0; we[0] = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         total++; if ({ack1, ack0, reg_load, lock_err, owner} !== {m_ack, m_load, m_err, (m_owner < 0) ? 2'b00 : (m_owner == 0 ? 2'b01 : 2'b10)}) begin
            bad++; $display("[TB] FAIL random_ctrl[%0d] got=%b exp=%b", i, {ack1, ack0, reg_load, lock_err, owner}, {m_ack, m_load, m_err, (m_owner < 0) ? 2'b00 : (m_owner == 0 ? 2'b01 : 2'b10)});
         end
         total++; if (reg_in !== m_in) begin bad++; $display("[TB] FAIL random_reg_in[%0d] got=%h exp=%h", i, reg_in, m_in); end
         total++; if (rdata !== m_reg) begin bad++; $display("[TB] FAIL random_rdata[%0d] got=%h exp=%h", i, rdata, m_reg); end
         for (int n = 0; n < 2; n++) begin
            if (req[n] && ((n == 0) ? ack0 : ack1)) begin
               req[n] = 1'b0;
               if ($urandom_range(1, 0) == 0) lock[n] = 1'b0;
            end else if (!req[n] && $urandom_range(2, 0) == 0) begin
               req[n]   = 1'b1;
               we[n]    = 1'($urandom_range(1, 0));
               wdata[n] = 16'($urandom);
               lock[n]  = ($urandom_range(3, 0) == 0);
            end
         end
      end
      req = 2'b00; lock = 2'b00;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL timeout simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      test_reset();
      test_write_read();
      test_contention();
      test_lock_rmw();
      test_watchdog();
      test_reset_mid_write();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
